mc_controller: RTL
==================

# mc_controller

Multicycle control unit for the ARM datapath: a registered finite-state machine that sequences each instruction over 3–5 cycles. It combines three functions:
- instruction decode and ALU decode;
- a NZCV flag register with full ARM condition evaluation;
- PC-write logic.

It replaces the single-cycle combinational decoder. The datapath can then share one memory and one ALU across cycles, while the decode rules stay the same (DP imm/reg, LDR/STR, B, ADD/SUB/AND/ORR).

## Interface
Parameters:
- ALUCTRL_W, default 3: ALUControl width. Must be ≥3.
- RESET_FLAGS, default 4'b0000: NZCV value loaded on reset.

Ports:
- clk  in  1  clock. All state updates on the rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- Cond  in  4  Instr[31:28].
- Op  in  2  Instr[27:26].
- Funct  in  6  Instr[25:20]. Bit 5 = I, [4:1] = cmd, bit 0 = S/L.
- Rd  in  4  Instr[15:12].
- ALUFlags  in  4  NZCV from the ALU in the current cycle.
- PCWrite, MemWrite, RegWrite, IRWrite  out  1 each  datapath write enables.
- AdrSrc  out  1  0 = PC, 1 = ALUOut.
- ALUSrcA  out  1  0 = register A, 1 = PC.
- ALUSrcB  out  2  00 = register, 01 = ExtImm, 10 = constant 4.
- ResultSrc  out  2  00 = ALUOut, 01 = ReadData, 10 = ALUResult.
- ImmSrc, RegSrc  out  2 each  same encoding as the existing decoder.
- ALUControl  out  ALUCTRL_W  000 ADD, 001 SUB, 010 AND, 011 ORR, 100 EOR.
- Undef  out  1  one-cycle pulse when an unimplemented opcode is decoded.
- Flags  out  4  current NZCV register, for debug.

## Operation
- States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECUTER, EXECUTEI, ALUWB, BRANCH.
- FETCH: IRWrite=1, AdrSrc=0, ALUSrcA=1, ALUSrcB=10, ResultSrc=10, PCWrite=1. Always goes to DECODE.
- DECODE: ALUSrcA=1, ALUSrcB=10, ResultSrc=10, no writes. Next state by opcode:
  - Op=00, I=1 → EXECUTEI.
  - Op=00, I=0 → EXECUTER.
  - Op=01 → MEMADR.
  - Op=10 → BRANCH.
  - Op=11, or an unimplemented cmd → FETCH, with Undef=1.
- MEMADR: ALUSrcA=0, ALUSrcB=01, ALUControl=ADD. L=1 → MEMREAD, L=0 → MEMWRITE.
- MEMREAD: AdrSrc=1 → MEMWB.
- MEMWB: ResultSrc=01, RegWrite gated → FETCH.
- MEMWRITE: AdrSrc=1, MemWrite gated → FETCH.
- EXECUTER: ALUSrcB=00. EXECUTEI: ALUSrcB=01. Both drive ALUControl from cmd, then go to ALUWB.
- ALUWB: ResultSrc=00, RegWrite gated → FETCH.
- BRANCH: ALUSrcA=0, ALUSrcB=01, ADD, ResultSrc=10, PCWrite gated → FETCH.
- ALU decode: cmd 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR. Non-DP states drive ADD.
- Condition gating:
  - Condition code evaluated against the Flags register: EQ/NE/CS/CC/MI/PL/VS/VC/HI/LS/GE/LT/GT/LE/AL; 1111 → false.
  - The result is registered as cond_q at the end of DECODE.
  - Every gated write in later states is ANDed with cond_q.
- PCWrite = (state==FETCH) | (cond_q & PCS). PCS = (Rd==15 & RegW-state) | BRANCH.
- Flag update, only in EXECUTER/EXECUTEI with S=1 and cond_q=1:
  - NZ are always loaded from ALUFlags.
  - CV are loaded only for ADD/SUB.
  - Flags are written at the end of the execute cycle.

## Timing
- Instruction latency in cycles: B 3, STR 4, DP 4, LDR 5, undefined 2.
- Control outputs are Moore functions of state, with Op/Funct decoded combinationally in the same cycle.
- Reset (rst_n low, asynchronous): state=FETCH, Flags=RESET_FLAGS, cond_q=0. While rst_n=0, all write enables are forced to 0 and Undef=0.
- Reset asserted mid-instruction aborts it immediately. No write enable is asserted in the cycle after release except FETCH's own.
- A DP instruction with S=1 and a false condition leaves both Flags and registers unchanged.
- A flag write in EXECUTE is visible to the following instruction's DECODE.

## Configuration
- CTRL_EXT_ALU_EN defined:
  - cmd 0001 → EOR (100).
  - cmd 1010 (CMP) → SUB with RegWrite suppressed in ALUWB and flags forced to update.
  - cmd 1000 (TST) → AND, same suppression.
- Undefined: those cmd values are unimplemented and take the Undef path.

## Structure
- Package arm_ctrl_pkg holds:
  - the state enum (state_t);
  - ALU op localparams;
  - condition-code localparams;
  - the control-word typedef.
- Sub-module cond_unit contains the Flags register, condition evaluation, cond_q and flag-write gating.
- The FSM and decoders live in mc_controller.

## Test plan
- Reset then ADD R1,R2,#5 (Op=00, Funct=101000, Cond=1110) → FETCH, DECODE, EXECUTEI, ALUWB. RegWrite=1 only in ALUWB; ALUControl=000.
- LDR (Op=01, Funct=011001) → 5 cycles. MEMREAD has AdrSrc=1; MEMWB has ResultSrc=01 and RegWrite=1.
- SUBS giving zero (ALUFlags=0100), then BEQ (Cond=0000) → Flags=0100 and PCWrite=1 in BRANCH. The same branch with Flags=0000 gives PCWrite=0.
- ADD with Rd=15 → PCWrite=1 in ALUWB.
- Op=11 → Undef pulses in DECODE, next state FETCH, and no write enables.
- rst_n dropped during MEMWRITE → MemWrite=0 immediately, state=FETCH, Flags=RESET_FLAGS. With CTRL_EXT_ALU_EN, CMP gives RegWrite=0 and updated flags.

Source files
------------

// File: rtl/arm_ctrl_pkg.sv
// Shared encodings for the multicycle ARM control unit: FSM states, ALU ops,
// data-processing commands, condition codes and the per-state control word.
package arm_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXECUTER, S_EXECUTEI, S_ALUWB, S_BRANCH
  } state_t;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_ORR = 3'b011;
  localparam logic [2:0] ALU_EOR = 3'b100;

  localparam logic [3:0] CMD_AND = 4'b0000;
  localparam logic [3:0] CMD_EOR = 4'b0001;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_TST = 4'b1000;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_ORR = 4'b1100;

  localparam logic [3:0] COND_EQ = 4'h0;
  localparam logic [3:0] COND_NE = 4'h1;
  localparam logic [3:0] COND_CS = 4'h2;
  localparam logic [3:0] COND_CC = 4'h3;
  localparam logic [3:0] COND_MI = 4'h4;
  localparam logic [3:0] COND_PL = 4'h5;
  localparam logic [3:0] COND_VS = 4'h6;
  localparam logic [3:0] COND_VC = 4'h7;
  localparam logic [3:0] COND_HI = 4'h8;
  localparam logic [3:0] COND_LS = 4'h9;
  localparam logic [3:0] COND_GE = 4'ha;
  localparam logic [3:0] COND_LT = 4'hb;
  localparam logic [3:0] COND_GT = 4'hc;
  localparam logic [3:0] COND_LE = 4'hd;
  localparam logic [3:0] COND_AL = 4'he;

  typedef struct packed {
    logic       irw;
    logic       pcupd;
    logic       adrsrc;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] resultsrc;
    logic       regw;
    logic       memw;
    logic       branch;
    logic       execute;
  } ctrl_t;

  function automatic logic cond_holds(input logic [3:0] cond, input logic [3:0] nzcv);
    logic n, z, c, v, r;
    {n, z, c, v} = nzcv;
    case (cond)
      COND_EQ: r = z;
      COND_NE: r = ~z;
      COND_CS: r = c;
      COND_CC: r = ~c;
      COND_MI: r = n;
      COND_PL: r = ~n;
      COND_VS: r = v;
      COND_VC: r = ~v;
      COND_HI: r = c & ~z;
      COND_LS: r = ~c | z;
      COND_GE: r = (n == v);
      COND_LT: r = (n != v);
      COND_GT: r = ~z & (n == v);
      COND_LE: r = z | (n != v);
      COND_AL: r = 1'b1;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/cond_unit.sv
// NZCV flag register, condition evaluation and the per-instruction
// condition latch that gates every later write.
module cond_unit
  import arm_ctrl_pkg::*;
#(
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] cond,
  input  logic       decode,
  input  logic       exec,
  input  logic       flag_req,
  input  logic       arith,
  input  logic [3:0] alu_flags,
  output logic [3:0] flags,
  output logic       cond_q
);

  logic nz_we, cv_we;

  assign nz_we = exec & flag_req & cond_q;
  assign cv_we = nz_we & arith;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flags  <= RESET_FLAGS;
      cond_q <= 1'b0;
    end else begin
      if (decode) cond_q <= cond_holds(cond, flags);
      if (nz_we)  flags[3:2] <= alu_flags[3:2];
      if (cv_we)  flags[1:0] <= alu_flags[1:0];
    end
  end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM control FSM with instruction/ALU decode and PC-write logic.
// Define CTRL_EXT_ALU_EN to add EOR, CMP and TST to the data-processing set.
module mc_controller
  import arm_ctrl_pkg::*;
#(
  parameter int         ALUCTRL_W   = 3,
  parameter logic [3:0] RESET_FLAGS = 4'b0000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [3:0]           Cond,
  input  logic [1:0]           Op,
  input  logic [5:0]           Funct,
  input  logic [3:0]           Rd,
  input  logic [3:0]           ALUFlags,
  output logic                 PCWrite,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic                 IRWrite,
  output logic                 AdrSrc,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [1:0]           ResultSrc,
  output logic [1:0]           ImmSrc,
  output logic [1:0]           RegSrc,
  output logic [ALUCTRL_W-1:0] ALUControl,
  output logic                 Undef,
  output logic [3:0]           Flags
);

  // state      | meaning
  // FETCH      | load IR, PC <= PC+4
  // DECODE     | read registers, pick path by opcode
  // MEMADR     | base + offset address
  // MEMREAD    | read data memory at ALUOut
  // MEMWB      | write loaded word to Rd
  // MEMWRITE   | store to data memory at ALUOut
  // EXECUTER   | DP op, register operand
  // EXECUTEI   | DP op, immediate operand
  // ALUWB      | write ALU result to Rd
  // BRANCH     | PC <= PC+8+offset

  state_t     state_q, state_d;
  ctrl_t      ctrl;
  logic [3:0] cmd;
  logic [2:0] alu_op, alu_sel;
  logic       cmd_ok, nowrite, force_flags, undef_dec;
  logic       cond_q, regw_st, pcs;

  assign cmd = Funct[4:1];

  always_comb begin
    alu_op      = ALU_ADD;
    cmd_ok      = 1'b1;
    nowrite     = 1'b0;
    force_flags = 1'b0;
    case (cmd)
      CMD_ADD: alu_op = ALU_ADD;
      CMD_SUB: alu_op = ALU_SUB;
      CMD_AND: alu_op = ALU_AND;
      CMD_ORR: alu_op = ALU_ORR;
`ifdef CTRL_EXT_ALU_EN
      CMD_EOR: alu_op = ALU_EOR;
      CMD_CMP: begin alu_op = ALU_SUB; nowrite = 1'b1; force_flags = 1'b1; end
      CMD_TST: begin alu_op = ALU_AND; nowrite = 1'b1; force_flags = 1'b1; end
`endif
      default: cmd_ok = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    undef_dec = 1'b0;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (Op)
          2'b00: begin
            if (!cmd_ok) begin
              state_d   = S_FETCH;
              undef_dec = 1'b1;
            end else begin
              state_d = Funct[5] ? S_EXECUTEI : S_EXECUTER;
            end
          end
          2'b01:   state_d = S_MEMADR;
          2'b10:   state_d = S_BRANCH;
          default: begin state_d = S_FETCH; undef_dec = 1'b1; end
        endcase
      end
      S_MEMADR:   state_d = Funct[0] ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  state_d = S_MEMWB;
      S_EXECUTER: state_d = S_ALUWB;
      S_EXECUTEI: state_d = S_ALUWB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    ctrl = '0;
    case (state_q)
      S_FETCH: begin
        ctrl.irw = 1'b1; ctrl.pcupd = 1'b1; ctrl.alusrca = 1'b1;
        ctrl.alusrcb = 2'b10; ctrl.resultsrc = 2'b10;
      end
      S_DECODE: begin
        ctrl.alusrca = 1'b1; ctrl.alusrcb = 2'b10; ctrl.resultsrc = 2'b10;
      end
      S_MEMADR:   ctrl.alusrcb = 2'b01;
      S_MEMREAD:  ctrl.adrsrc = 1'b1;
      S_MEMWB:    begin ctrl.resultsrc = 2'b01; ctrl.regw = 1'b1; end
      S_MEMWRITE: begin ctrl.adrsrc = 1'b1; ctrl.memw = 1'b1; end
      S_EXECUTER: ctrl.execute = 1'b1;
      S_EXECUTEI: begin ctrl.alusrcb = 2'b01; ctrl.execute = 1'b1; end
      S_ALUWB:    ctrl.regw = ~nowrite;
      S_BRANCH: begin
        ctrl.alusrcb = 2'b01; ctrl.resultsrc = 2'b10; ctrl.branch = 1'b1;
      end
      default: ;
    endcase
  end

  cond_unit #(.RESET_FLAGS(RESET_FLAGS)) u_cond (
    .clk       (clk),
    .rst_n     (rst_n),
    .cond      (Cond),
    .decode    (state_q == S_DECODE),
    .exec      (ctrl.execute),
    .flag_req  (Funct[0] | force_flags),
    .arith     ((alu_op == ALU_ADD) | (alu_op == ALU_SUB)),
    .alu_flags (ALUFlags),
    .flags     (Flags),
    .cond_q    (cond_q)
  );

  // Write enables are also forced low combinationally while reset is held.
  assign regw_st  = ctrl.regw;
  assign pcs      = ((Rd == 4'hf) & regw_st) | ctrl.branch;
  assign PCWrite  = rst_n & (ctrl.pcupd | (cond_q & pcs));
  assign MemWrite = rst_n & cond_q & ctrl.memw;
  assign RegWrite = rst_n & cond_q & regw_st;
  assign IRWrite  = rst_n & ctrl.irw;
  assign Undef    = rst_n & undef_dec;

  assign AdrSrc    = ctrl.adrsrc;
  assign ALUSrcA   = ctrl.alusrca;
  assign ALUSrcB   = ctrl.alusrcb;
  assign ResultSrc = ctrl.resultsrc;
  assign ImmSrc    = Op;
  assign RegSrc    = {Op == 2'b01, Op == 2'b10};

  assign alu_sel    = ctrl.execute ? alu_op : ALU_ADD;
  assign ALUControl = ALUCTRL_W'(alu_sel);

endmodule
